// File: rtl/axil_csr_bank_if.sv
// AXI4-Lite slave channel bundle for the CSR bank: 32-bit address/data, 4-bit strobe, 2-bit response.
interface axil_csr_bank_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: RW control registers with byte strobes, RO status words,
// per-register write pulses and a pending/enable interrupt unit.
//
// state   | meaning
// IDLE    | no transaction; accepts AW, W or AR
// WAIT_W  | write address held, waiting for write data
// WAIT_AW | write data held, waiting for write address
// WRESP   | write committed, B beat presented until BREADY
// RADDR   | read address held, RDATA loaded at end of this cycle
// RDATA   | R beat presented until RREADY
module axil_csr_bank #(
  parameter int          NREG      = 4,
  parameter int          NSTAT     = 2,
  parameter int          NEVT      = 4,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  axil_csr_bank_if.slave      s_axi,
  output logic [NREG*32-1:0]  ctrl_o,
  output logic [NREG-1:0]     wr_pulse_o,
  input  logic [NSTAT*32-1:0] stat_i,
  input  logic [NEVT-1:0]     evt_i,
  output logic                irq_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    WRESP   = 3'd3,
    RADDR   = 3'd4,
    RDATA   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                  state_q, state_d;
  logic [9:0]              awaddr_q, araddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [NREG-1:0][31:0]   ctrl_q;
  logic [NREG-1:0]         wr_pulse_q;
  logic [NEVT-1:0]         en_q, pend_q, pend_d, pend_clr;
  logic                    irq_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [31:0]             rdata_q;

  logic                    aw_fire, w_fire, ar_fire, commit;
  logic [9:0]              waddr;
  logic [31:0]             wdata_c, wmask, wval;
  logic [3:0]              wstrb_c;
  logic [NREG-1:0]         w_sel;
  logic                    w_en_hit, w_pend_hit, w_ok;
  logic [31:0]             rd_val;
  logic                    rd_ok;

  // Only ADDR[11:2] takes part in decode.
  logic unused_addr;
  assign unused_addr = ^{s_axi.awaddr[31:12], s_axi.awaddr[1:0],
                         s_axi.araddr[31:12], s_axi.araddr[1:0]};

  assign s_axi.awready = S_AXI_ARESETN && (state_q == IDLE || state_q == WAIT_AW);
  assign s_axi.wready  = S_AXI_ARESETN && (state_q == IDLE || state_q == WAIT_W);
  assign s_axi.arready = S_AXI_ARESETN && (state_q == IDLE);
  assign s_axi.bvalid  = (state_q == WRESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = (state_q == RDATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign ctrl_o     = ctrl_q;
  assign wr_pulse_o = wr_pulse_q;
  assign irq_o      = irq_q;

  assign aw_fire = s_axi.awvalid && s_axi.awready;
  assign w_fire  = s_axi.wvalid && s_axi.wready;
  assign ar_fire = s_axi.arvalid && s_axi.arready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) state_d = WRESP;
        else if (s_axi.awvalid)            state_d = WAIT_W;
        else if (s_axi.wvalid)             state_d = WAIT_AW;
        else if (s_axi.arvalid)            state_d = RADDR;
      end
      WAIT_W:  if (s_axi.wvalid)  state_d = WRESP;
      WAIT_AW: if (s_axi.awvalid) state_d = WRESP;
      WRESP:   if (s_axi.bready)  state_d = IDLE;
      RADDR:   state_d = RDATA;
      RDATA:   if (s_axi.rready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The commit edge may complete either channel, so take whichever half is live.
  assign commit  = (state_q != WRESP) && (state_d == WRESP);
  assign waddr   = (state_q == WAIT_W)  ? awaddr_q : s_axi.awaddr[11:2];
  assign wdata_c = (state_q == WAIT_AW) ? wdata_q  : s_axi.wdata;
  assign wstrb_c = (state_q == WAIT_AW) ? wstrb_q  : s_axi.wstrb;

  always_comb begin
    wmask = '0;
    for (int k = 0; k < 4; k++) wmask[8*k +: 8] = {8{wstrb_c[k]}};
    wval  = wdata_c & wmask;
    w_sel = '0;
    for (int i = 0; i < NREG; i++)
      if (waddr[9:6] == 4'h0 && waddr[5:0] == 6'(i)) w_sel[i] = 1'b1;
    w_en_hit   = (waddr == 10'h080);
    w_pend_hit = (waddr == 10'h081);
    w_ok       = (|w_sel) || w_en_hit || w_pend_hit;
    pend_clr   = (commit && w_pend_hit) ? wval[NEVT-1:0] : '0;
    pend_d     = (pend_q & ~pend_clr) | evt_i;
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (araddr_q[9:6] == 4'h0 && araddr_q[5:0] == 6'(i)) begin
        rd_val = ctrl_q[i];
        rd_ok  = 1'b1;
      end
    for (int j = 0; j < NSTAT; j++)
      if (araddr_q[9:6] == 4'h1 && araddr_q[5:0] == 6'(j)) begin
        rd_val = stat_i[32*j +: 32];
        rd_ok  = 1'b1;
      end
    if (araddr_q == 10'h080) begin
      rd_val = 32'(en_q);
      rd_ok  = 1'b1;
    end
    if (araddr_q == 10'h081) begin
      rd_val = 32'(pend_q);
      rd_ok  = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ctrl_q     <= {NREG{RESET_VAL}};
      wr_pulse_q <= '0;
      en_q       <= '0;
      pend_q     <= '0;
      irq_q      <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (aw_fire) awaddr_q <= s_axi.awaddr[11:2];
      if (w_fire) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (ar_fire) araddr_q <= s_axi.araddr[11:2];
      wr_pulse_q <= commit ? w_sel : '0;
      if (commit) begin
        bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NREG; i++)
          if (w_sel[i]) ctrl_q[i] <= (ctrl_q[i] & ~wmask) | wval;
        if (w_en_hit) en_q <= (en_q & ~wmask[NEVT-1:0]) | wval[NEVT-1:0];
      end
      pend_q <= pend_d;
      irq_q  <= |(pend_q & en_q);
      if (state_q == RADDR) begin
        rdata_q <= rd_ok ? rd_val : '0;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_csr_bank.sv
// Self-checking bench for axil_csr_bank: directed scenarios plus randomized
// traffic checked against an address-map level reference model.
module tb_axil_csr_bank;
  localparam int          NREG  = 4;
  localparam int          NSTAT = 2;
  localparam int          NEVT  = 4;
  localparam logic [31:0] RV    = 32'h0;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREG*32-1:0]    ctrl;
  logic [NREG-1:0]       wr_pulse;
  logic [NSTAT*32-1:0]   stat;
  logic [NEVT-1:0]       evt;
  logic                  irq;

  int checks = 0;
  int passed = 0;

  logic [31:0]     ctrl_m [NREG];
  logic [NEVT-1:0] en_m, pend_m;

  axil_csr_bank_if bus ();

  axil_csr_bank #(.NREG(NREG), .NSTAT(NSTAT), .NEVT(NEVT), .RESET_VAL(RV)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .s_axi         (bus),
    .ctrl_o        (ctrl),
    .wr_pulse_o    (wr_pulse),
    .stat_i        (stat),
    .evt_i         (evt),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset;
    for (int i = 0; i < NREG; i++) ctrl_m[i] = RV;
    en_m   = '0;
    pend_m = '0;
  endtask

  function automatic logic [NREG*32-1:0] model_ctrl();
    logic [NREG*32-1:0] v;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = ctrl_m[i];
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NREG-1:0] pulse);
    int          w;
    logic [31:0] m, dm;
    w = int'((addr & 32'hFFF) >> 2);
    for (int k = 0; k < 4; k++) m[8*k +: 8] = strb[k] ? 8'hFF : 8'h00;
    dm    = data & m;
    pulse = '0;
    resp  = 2'b10;
    if (w < NREG) begin
      ctrl_m[w] = (ctrl_m[w] & ~m) | dm;
      pulse[w]  = 1'b1;
      resp      = 2'b00;
    end else if (w == 128) begin
      en_m = (en_m & ~m[NEVT-1:0]) | dm[NEVT-1:0];
      resp = 2'b00;
    end else if (w == 129) begin
      pend_m = pend_m & ~dm[NEVT-1:0];
      resp   = 2'b00;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int w;
    w    = int'((addr & 32'hFFF) >> 2);
    data = '0;
    resp = 2'b00;
    if (w < NREG)                        data = ctrl_m[w];
    else if (w >= 64 && w < 64 + NSTAT)  data = stat[32*(w-64) +: 32];
    else if (w == 128)                   data = 32'(en_m);
    else if (w == 129)                   data = 32'(pend_m);
    else                                 resp = 2'b10;
  endtask

  // ---------------- bus drivers (no checking) ----------------
  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bwait,
                             output logic [1:0] resp, output int npulse, output logic [NREG-1:0] pvec,
                             output logic [NREG*32-1:0] ctrl_bv, output bit held, output bit tmo);
    int cyc;
    bit aw_p, w_p, aw_hs, w_hs, got_b;
    aw_p = 1; w_p = 1; cyc = 0; got_b = 0;
    npulse = 0; pvec = '0; held = 1; tmo = 0; resp = 2'b11; ctrl_bv = '0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!got_b && !tmo) begin
      bus.awvalid = aw_p && (cyc >= ((lead > 0) ? lead : 0));
      bus.wvalid  = w_p  && (cyc >= ((lead < 0) ? -lead : 0));
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      tick;
      cyc++;
      if (aw_hs) aw_p = 0;
      if (w_hs)  w_p  = 0;
      if (wr_pulse != '0) begin npulse++; pvec |= wr_pulse; end
      if (bus.bvalid) begin got_b = 1; resp = bus.bresp; ctrl_bv = ctrl; end
      if (cyc > 60) tmo = 1;
    end
    bus.awvalid = 0;
    bus.wvalid  = 0;
    if (!tmo) begin
      for (int k = 0; k < bwait; k++) begin
        tick;
        if (!bus.bvalid || bus.bresp !== resp) held = 0;
        if (wr_pulse != '0) begin npulse++; pvec |= wr_pulse; end
      end
      bus.bready = 1;
      tick;
      bus.bready = 0;
      if (wr_pulse != '0) begin npulse++; pvec |= wr_pulse; end
    end
  endtask

  task automatic drive_read(input logic [31:0] addr, input int rwait,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output bit stable, output bit tmo);
    bit hs;
    int n;
    bus.araddr = addr; bus.arvalid = 1;
    tmo = 0; stable = 1; lat = 0; hs = 0; n = 0; data = '0; resp = 2'b11;
    while (!hs && n < 60) begin
      hs = bus.arready;
      tick;
      n++;
    end
    bus.arvalid = 0;
    if (!hs) tmo = 1;
    else begin
      lat = 1;
      while (!bus.rvalid && lat < 60) begin tick; lat++; end
      if (!bus.rvalid) tmo = 1;
      else begin
        data = bus.rdata;
        resp = bus.rresp;
        for (int k = 0; k < rwait; k++) begin
          tick;
          if (!bus.rvalid || bus.rdata !== data || bus.rresp !== resp) stable = 0;
        end
        bus.rready = 1;
        tick;
        bus.rready = 0;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rstn = 0;
    repeat (3) tick;
    model_reset();
    checks++; if (ctrl !== model_ctrl()) $display("FAIL reset_ctrl got=%h exp=%h", ctrl, model_ctrl()); else passed++;
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) $display("FAIL reset_ready got=%b exp=000", {bus.awready, bus.wready, bus.arready}); else passed++;
    checks++; if ({bus.bvalid, bus.rvalid, irq, wr_pulse} !== '0) $display("FAIL reset_valid got=%b exp=0", {bus.bvalid, bus.rvalid, irq, wr_pulse}); else passed++;
    checks++; if ({bus.rdata, bus.rresp, bus.bresp} !== '0) $display("FAIL reset_rdata got=%h exp=0", {bus.rdata, bus.rresp, bus.bresp}); else passed++;
    rstn = 1;
    tick;
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) $display("FAIL reset_idle got=%b exp=111", {bus.awready, bus.wready, bus.arready}); else passed++;
  endtask

  task automatic test_basic_write;
    logic [1:0] resp, eresp; int np; logic [NREG-1:0] pv, ep; logic [NREG*32-1:0] cb; bit held, tmo;
    drive_write(32'h000, 32'h7, 4'hF, 0, 0, resp, np, pv, cb, held, tmo);
    model_write(32'h000, 32'h7, 4'hF, eresp, ep);
    checks++; if (tmo) $display("FAIL basic_timeout got=timeout exp=bvalid"); else passed++;
    checks++; if (cb[31:0] !== 32'h7) $display("FAIL basic_ctrl0 got=%h exp=00000007", cb[31:0]); else passed++;
    checks++; if (resp !== 2'b00) $display("FAIL basic_bresp got=%b exp=00", resp); else passed++;
    checks++; if (np !== 1 || pv !== ep) $display("FAIL basic_pulse got=%0d/%b exp=1/%b", np, pv, ep); else passed++;
  endtask

  task automatic test_w_first;
    logic [1:0] resp, eresp; int np; logic [NREG-1:0] pv, ep; logic [NREG*32-1:0] cb; bit held, tmo;
    drive_write(32'h004, 32'hAABBCCDD, 4'b0010, 3, 5, resp, np, pv, cb, held, tmo);
    model_write(32'h004, 32'hAABBCCDD, 4'b0010, eresp, ep);
    checks++; if (tmo) $display("FAIL wfirst_timeout got=timeout exp=bvalid"); else passed++;
    checks++; if (cb[63:32] !== 32'h0000CC00) $display("FAIL wfirst_ctrl1 got=%h exp=0000cc00", cb[63:32]); else passed++;
    checks++; if (np !== 1 || pv !== 4'b0010) $display("FAIL wfirst_pulse got=%0d/%b exp=1/0010", np, pv); else passed++;
    checks++; if (!held) $display("FAIL wfirst_bvalid_held got=dropped exp=held"); else passed++;
    checks++; if (ctrl !== model_ctrl()) $display("FAIL wfirst_all got=%h exp=%h", ctrl, model_ctrl()); else passed++;
  endtask

  task automatic test_status_read;
    logic [31:0] d; logic [1:0] r; int lat; bit st, tmo;
    stat = {32'h12345678, 32'h0BADF00D};
    drive_read(32'h104, 4, d, r, lat, st, tmo);
    checks++; if (tmo) $display("FAIL stat_timeout got=timeout exp=rvalid"); else passed++;
    checks++; if (lat !== 2) $display("FAIL stat_latency got=%0d exp=2", lat); else passed++;
    checks++; if (d !== 32'h12345678 || r !== 2'b00) $display("FAIL stat_data got=%h/%b exp=12345678/00", d, r); else passed++;
    checks++; if (!st) $display("FAIL stat_stable got=changed exp=stable"); else passed++;
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL stat_rvalid_drop got=%b exp=0", bus.rvalid); else passed++;
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic [1:0] r, eresp; int lat, np; bit st, tmo, held; logic [NREG-1:0] pv, ep; logic [NREG*32-1:0] cb;
    drive_read(32'h400, 0, d, r, lat, st, tmo);
    checks++; if (r !== 2'b10 || d !== 32'h0) $display("FAIL unmap_read got=%h/%b exp=00000000/10", d, r); else passed++;
    drive_write(32'h0FC, 32'hFFFFFFFF, 4'hF, -1, 1, r, np, pv, cb, held, tmo);
    model_write(32'h0FC, 32'hFFFFFFFF, 4'hF, eresp, ep);
    checks++; if (r !== 2'b10) $display("FAIL unmap_wresp got=%b exp=10", r); else passed++;
    checks++; if (np !== 0 || cb !== model_ctrl()) $display("FAIL unmap_effect got=%0d/%h exp=0/%h", np, cb, model_ctrl()); else passed++;
    drive_write(32'h100, 32'h1, 4'hF, 0, 0, r, np, pv, cb, held, tmo);
    model_write(32'h100, 32'h1, 4'hF, eresp, ep);
    checks++; if (r !== 2'b10 || np !== 0) $display("FAIL stat_write got=%b/%0d exp=10/0", r, np); else passed++;
  endtask

  task automatic test_irq;
    logic [1:0] r, eresp; int np, lat; logic [NREG-1:0] pv, ep; logic [NREG*32-1:0] cb; bit held, tmo, st;
    logic [31:0] d, ed;
    drive_write(32'h200, 32'h1, 4'hF, 0, 0, r, np, pv, cb, held, tmo);
    model_write(32'h200, 32'h1, 4'hF, eresp, ep);
    evt = 4'b0001;
    tick;
    evt = '0;
    pend_m[0] = 1'b1;
    checks++; if (irq !== 1'b0) $display("FAIL irq_lag got=%b exp=0", irq); else passed++;
    tick;
    checks++; if (irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", irq); else passed++;
    // clear while the event is still asserted: set must win
    evt = 4'b0001;
    drive_write(32'h204, 32'h1, 4'hF, 0, 0, r, np, pv, cb, held, tmo);
    model_write(32'h204, 32'h1, 4'hF, eresp, ep);
    pend_m[0] = 1'b1;
    evt = '0;
    drive_read(32'h204, 0, d, r, lat, st, tmo);
    model_read(32'h204, ed, eresp);
    checks++; if (d !== ed) $display("FAIL irq_set_wins got=%h exp=%h", d, ed); else passed++;
    checks++; if (irq !== 1'b1) $display("FAIL irq_held got=%b exp=1", irq); else passed++;
    drive_write(32'h204, 32'h1, 4'hF, 0, 0, r, np, pv, cb, held, tmo);
    model_write(32'h204, 32'h1, 4'hF, eresp, ep);
    drive_read(32'h204, 0, d, r, lat, st, tmo);
    model_read(32'h204, ed, eresp);
    checks++; if (d !== ed) $display("FAIL irq_w1c got=%h exp=%h", d, ed); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq); else passed++;
    // masked source: pending but no interrupt
    evt = 4'b0100;
    tick;
    evt = '0;
    pend_m[2] = 1'b1;
    drive_read(32'h204, 0, d, r, lat, st, tmo);
    model_read(32'h204, ed, eresp);
    checks++; if (d !== ed || irq !== 1'b0) $display("FAIL irq_masked got=%h/%b exp=%h/0", d, irq, ed); else passed++;
    drive_write(32'h204, 32'hF, 4'hF, 0, 0, r, np, pv, cb, held, tmo);
    model_write(32'h204, 32'hF, 4'hF, eresp, ep);
  endtask

  task automatic test_random;
    logic [31:0] addrs [15];
    logic [31:0] a, dat, d, ed;
    logic [3:0] s;
    logic [1:0] r, er;
    int np, lat;
    logic [NREG-1:0] pv, ep;
    logic [NREG*32-1:0] cb;
    bit held, tmo, st;
    addrs = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h0FC, 32'h100, 32'h104,
              32'h108, 32'h200, 32'h204, 32'h208, 32'h400, 32'h1008, 32'h00E};
    for (int t = 0; t < 40; t++) begin
      a = addrs[$urandom_range(0, 14)];
      if ($urandom_range(0, 1) == 0) begin
        dat = $urandom;
        s   = 4'($urandom);
        drive_write(a, dat, s, $urandom_range(0, 4) - 2, $urandom_range(0, 2), r, np, pv, cb, held, tmo);
        model_write(a, dat, s, er, ep);
        checks++;
        if (tmo || r !== er || cb !== model_ctrl() || pv !== ep || np !== ((ep != '0) ? 1 : 0) || !held)
          $display("FAIL rand_write a=%h got=%b/%h/%b/%0d exp=%b/%h/%b", a, r, cb, pv, np, er, model_ctrl(), ep);
        else passed++;
      end else begin
        stat = {$urandom, $urandom};
        drive_read(a, $urandom_range(0, 2), d, r, lat, st, tmo);
        model_read(a, ed, er);
        checks++;
        if (tmo || d !== ed || r !== er || !st)
          $display("FAIL rand_read a=%h got=%h/%b exp=%h/%b", a, d, r, ed, er);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, ed; logic [1:0] r, er; int lat; bit st, tmo; bit bseen;
    bus.awaddr = 32'h008; bus.awvalid = 1; bus.wvalid = 0;
    tick;
    bus.awvalid = 0;
    checks++; if ({bus.awready, bus.wready} !== 2'b01) $display("FAIL mid_wait_w got=%b exp=01", {bus.awready, bus.wready}); else passed++;
    rstn = 0;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1;
    #1;
    checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) $display("FAIL mid_ready got=%b exp=000", {bus.awready, bus.wready, bus.arready}); else passed++;
    bseen = 0;
    repeat (3) begin tick; if (bus.bvalid) bseen = 1; end
    bus.wvalid = 0;
    model_reset();
    checks++; if (bseen) $display("FAIL mid_bvalid got=1 exp=0"); else passed++;
    checks++; if (ctrl !== model_ctrl()) $display("FAIL mid_ctrl got=%h exp=%h", ctrl, model_ctrl()); else passed++;
    rstn = 1;
    tick;
    checks++; if ({bus.awready, bus.wready, bus.arready, bus.bvalid} !== 4'b1110) $display("FAIL mid_idle got=%b exp=1110", {bus.awready, bus.wready, bus.arready, bus.bvalid}); else passed++;
    drive_read(32'h200, 0, d, r, lat, st, tmo);
    model_read(32'h200, ed, er);
    checks++; if (tmo || d !== ed || r !== er) $display("FAIL mid_en_reset got=%h/%b exp=%h/%b", d, r, ed, er); else passed++;
    drive_read(32'h008, 0, d, r, lat, st, tmo);
    model_read(32'h008, ed, er);
    checks++; if (tmo || d !== ed || r !== er) $display("FAIL mid_ctrl2 got=%h/%b exp=%h/%b", d, r, ed, er); else passed++;
  endtask

  initial begin
    rstn = 0; stat = '0; evt = '0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    model_reset();
    test_reset();
    test_basic_write();
    test_w_first();
    test_status_read();
    test_unmapped();
    test_irq();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
